// File: rtl/lsu_if.sv
// Handshake and data-bus signals of the load/store unit, bundled for port connection.
// The slave modport is the LSU's view; master is the surrounding EXU/bus environment.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;
    logic        bus_resp_err;

    modport slave (
        input  req_valid, mem_rd, mem_wr, mem_op, addr, wdata,
        input  bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wmask
    );

    modport master (
        output req_valid, mem_rd, mem_wr, mem_op, addr, wdata,
        output bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wmask
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one memory instruction becomes one aligned-word bus transaction
// with byte mask; load data is lane-extracted and sign/zero-extended.
module lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave io
);
    // state  | meaning
    // IDLE   | ready for a request; request fields latched on accept
    // REQ    | bus_req_valid asserted, waiting for bus_req_ready
    // WAIT   | request accepted by bus, waiting for bus_resp_valid
    // RESP   | one-cycle resp_valid pulse, then back to IDLE

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wmask_q, bus_wmask_d;

    logic        op_bad;
    logic        store_uns;
    logic        misalign;
    logic        illegal;
    logic        noop;
    logic [3:0]  fmt_mask;
    logic [31:0] fmt_wdata;
    logic [31:0] shifted;
    logic [31:0] fmt_rdata;
    logic        tmo_hit;

    always_comb begin
        op_bad    = (io.mem_op == 3'b011) || (io.mem_op[2:1] == 2'b11);
        store_uns = io.mem_wr && io.mem_op[2];
        misalign  = ((io.mem_op[1:0] == 2'b01) && io.addr[0]) ||
                    ((io.mem_op[1:0] == 2'b10) && (io.addr[1:0] != 2'b00));
        illegal   = (io.mem_rd && io.mem_wr) || op_bad || store_uns || misalign;
        noop      = !io.mem_rd && !io.mem_wr;

        case (io.mem_op[1:0])
            2'b00: begin
                fmt_mask  = 4'b0001 << io.addr[1:0];
                fmt_wdata = {4{io.wdata[7:0]}};
            end
            2'b01: begin
                fmt_mask  = 4'b0011 << {io.addr[1], 1'b0};
                fmt_wdata = {2{io.wdata[15:0]}};
            end
            default: begin
                fmt_mask  = 4'b1111;
                fmt_wdata = io.wdata;
            end
        endcase
    end

    always_comb begin
        shifted = io.bus_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  fmt_rdata = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  fmt_rdata = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  fmt_rdata = {24'h0, shifted[7:0]};
            3'b101:  fmt_rdata = {16'h0, shifted[15:0]};
            default: fmt_rdata = io.bus_rdata;
        endcase
    end

    assign tmo_hit = (tmo_q == '0);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        tmo_d        = tmo_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wmask_d  = bus_wmask_q;

        case (state_q)
            S_IDLE: begin
                if (io.req_valid) begin
                    op_d         = io.mem_op;
                    off_d        = io.addr[1:0];
                    tmo_d        = TMO_LOAD;
                    resp_rdata_d = 32'h0;
                    if (illegal) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else if (noop) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b0;
                    end else begin
                        state_d     = S_REQ;
                        bus_we_d    = io.mem_wr;
                        bus_addr_d  = {io.addr[31:2], 2'b00};
                        bus_wmask_d = io.mem_wr ? fmt_mask : 4'b0000;
                        bus_wdata_d = io.mem_wr ? fmt_wdata : 32'h0;
                    end
                end
            end
            S_REQ: begin
                tmo_d = tmo_q - TW'(1);
                // A handshake on the last allowed cycle still times out.
                if (tmo_hit) begin
                    state_d      = S_RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end else if (io.bus_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q - TW'(1);
                // A response on the last allowed cycle beats the timeout.
                if (io.bus_resp_valid) begin
                    state_d      = S_RESP;
                    resp_err_d   = io.bus_resp_err;
                    resp_rdata_d = (io.bus_resp_err || bus_we_q) ? 32'h0 : fmt_rdata;
                end else if (tmo_hit) begin
                    state_d      = S_RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
        endcase

        req_ready_d     = (state_d == S_IDLE);
        resp_valid_d    = (state_d == S_RESP);
        bus_req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            op_q            <= 3'b000;
            off_q           <= 2'b00;
            tmo_q           <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0;
            resp_err_q      <= 1'b0;
            bus_req_valid_q <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_addr_q      <= 32'h0;
            bus_wdata_q     <= 32'h0;
            bus_wmask_q     <= 4'b0000;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            off_q           <= off_d;
            tmo_q           <= tmo_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_we_q        <= bus_we_d;
            bus_addr_q      <= bus_addr_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_wmask_q     <= bus_wmask_d;
        end
    end

    assign io.req_ready     = req_ready_q;
    assign io.resp_valid    = resp_valid_q;
    assign io.resp_rdata    = resp_rdata_q;
    assign io.resp_err      = resp_err_q;
    assign io.bus_req_valid = bus_req_valid_q;
    assign io.bus_we        = bus_we_q;
    assign io.bus_addr      = bus_addr_q;
    assign io.bus_wdata     = bus_wdata_q;
    assign io.bus_wmask     = bus_wmask_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the NPC RV32I core. It sits directly downstream of the control signal generator and consumes its MemRd/MemWr/MemOp outputs together with the EXU-computed address and rs2 data. It turns one memory instruction into one aligned-word data-bus transaction with a byte mask, waits for the response, and returns sign- or zero-extended load data. It also flags misaligned or illegal requests and bus timeouts.

## Interface
- TIMEOUT_CYC, 255, maximum cycles spent in REQ+WAIT before the transaction is abandoned with an error; must be ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  EXU presents a memory operation.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- mem_rd  in  1  MemRd from control: load.
- mem_wr  in  1  MemWr from control: store.
- mem_op  in  3  MemOp encoding: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
- addr  in  32  byte address.
- wdata  in  32  store data (rs2).
- resp_valid  out  1  single-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores, no-ops and errors.
- resp_err  out  1  qualifies resp_valid: request illegal, misaligned, bus error or timeout.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_wdata  out  32  replicated store data.
- bus_wmask  out  4  byte enables; 0000 for reads.
- bus_resp_valid  in  1  bus response.
- bus_rdata  in  32  read word.
- bus_resp_err  in  1  bus error qualifier.

## Operation
- States: IDLE, REQ, WAIT, RESP. Reset → IDLE.
- IDLE: when req_valid=1, latch mem_rd, mem_wr, mem_op, addr and wdata; clear the timeout counter. Next state:
  - RESP with err=1 if illegal;
  - RESP with err=0 if mem_rd=mem_wr=0 (no-op);
  - REQ otherwise.
- Illegal means any of:
  - mem_rd=mem_wr=1;
  - mem_op in {011,110,111};
  - store with mem_op[2]=1;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠00.
- Illegal requests never assert bus_req_valid.
- REQ: bus_req_valid=1 with all bus_* fields stable. On bus_req_ready=1 go to WAIT.
- WAIT: on bus_resp_valid=1 capture the result and go to RESP. resp_err=bus_resp_err; rdata is forced to 0 on error.
- bus_resp_valid is sampled only in WAIT; it is ignored in every other state.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure on the response.
- Write formatting:
  - byte: wmask=0001<<addr[1:0], wdata={4{wdata[7:0]}};
  - half: wmask=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}};
  - word: wmask=1111.
- Read formatting: shifted = bus_rdata >> (8*addr[1:0]). Result = shifted[7:0] or shifted[15:0], sign-extended if mem_op[2]=0, zero-extended if mem_op[2]=1; the word case passes through.
- Timeout: the counter increments every cycle in REQ or WAIT. When it equals TIMEOUT_CYC-1 and no handshake completes that cycle, go to RESP with err=1.
  - A completion (WAIT response) in the same cycle as the timeout wins.
  - A REQ→WAIT handshake in that same cycle does not prevent the timeout.
- After a timeout the bus contract forbids a late response to the abandoned request.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wmask=0.
- All outputs are derived from registered state and the latched request; there is no combinational path from the bus inputs to the resp_* outputs.
- Minimum legal latency: accept at cycle 0, REQ at 1 (bus_req_ready=1), WAIT at 2 (bus_resp_valid=1), resp_valid at cycle 3.
- Illegal or no-op requests: resp_valid at cycle 1.
- Back-to-back requests: a new accept is possible in the cycle after RESP.
- Reset mid-transaction: immediate return to IDLE with all outputs at their reset values; the pending transaction is dropped silently.

## Test plan
- lw at 0x80000004; bus ready immediately; bus_rdata 0xDEADBEEF the cycle after → bus_addr 0x80000004, wmask 0000, resp_valid at cycle 3, rdata 0xDEADBEEF, err 0.
- Loads at 0x80000003 and 0x80000002 with bus_rdata 0x80FF1234:
  - lb at 0x80000003 → 0xFFFFFF80;
  - lbu at 0x80000003 → 0x00000080;
  - lh at 0x80000002 → 0xFFFF80FF;
  - lhu at 0x80000002 → 0x000080FF.
- Stores:
  - sh at 0x80000002, wdata 0x1234ABCD → bus_addr 0x80000000, wmask 1100, bus_wdata 0xABCDABCD;
  - sb at 0x80000001, wdata 0x00000055 → wmask 0010, bus_wdata 0x55555555.
- Illegal requests each give resp_valid at cycle 1 with err=1 and bus_req_valid never asserted:
  - lw at 0x80000002;
  - lh at 0x80000001;
  - mem_op 011;
  - mem_rd=mem_wr=1.
- TIMEOUT_CYC=8, bus_req_ready held at 0 → bus_req_valid high for cycles 1–8, resp_valid with err=1 and rdata=0 at cycle 9. A bus_resp_err=1 response in WAIT instead → err=1, rdata=0.
- Reset asserted in WAIT, then bus_resp_valid pulsed after reset release → no resp_valid, outputs at reset values, next lw completes normally.
